// File: rtl/uart_cmd_engine_pkg.sv
// Shared definitions for the UART command engine: opcode fields, FSM states, reply defaults.
// The optional UART_CMD_CHECKSUM_EN build adds a per-packet XOR check byte to writes.
package uart_cmd_engine_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [7:0] PING_OP  = 8'h80;

  localparam logic [7:0] PING_REPLY_DEF = 8'hA5;
  localparam logic [7:0] ERR_REPLY_DEF  = 8'hEE;
  localparam logic [7:0] ACK_REPLY_DEF  = 8'h55;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_STB,
    S_RD_CAP,
    S_RESP_LO,
    S_RESP_HI,
    S_WR_LO,
    S_WR_HI,
    S_WR_CHK,
    S_WR_STB,
    S_RESP_ACK,
    S_RESP_1
  } state_t;

  // Check byte of a write packet: XOR of command, data LSB and data MSB.
  function automatic logic [7:0] wr_chk(input logic [5:0] addr,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi);
    return {OP_WRITE, addr} ^ lo ^ hi;
  endfunction

endpackage

// File: rtl/uart_cmd_engine.sv
// Byte-stream command engine: parses read/write/ping packets from UART rx, drives the register
// bus and returns reply bytes on UART tx. Define UART_CMD_CHECKSUM_EN for 4-byte checked writes.
import uart_cmd_engine_pkg::*;

module uart_cmd_engine #(
  parameter int unsigned TIMEOUT_CYCLES = 48000000,
  parameter logic [7:0]  PING_REPLY     = PING_REPLY_DEF,
  parameter logic [7:0]  ERR_REPLY      = ERR_REPLY_DEF,
  parameter logic [7:0]  ACK_REPLY      = ACK_REPLY_DEF
) (
  input  logic        clk_48,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic [5:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [15:0]       rdata_q;
  logic [7:0]        reply_q;
  logic              rx_fire, tx_fire, in_wr, tmo_hit;
  logic              tx_load, chk_ok;
  logic [7:0]        tx_byte;

  assign rx_fire = rx_data_valid && rx_data_ready;
  assign tx_fire = tx_data_valid && tx_data_ready;
  assign in_wr   = (state_q == S_WR_LO) || (state_q == S_WR_HI) || (state_q == S_WR_CHK);
  assign tmo_hit = in_wr && !rx_fire && (tmo_cnt == TMO_LAST);
  assign chk_ok  = (rx_data == wr_chk(reg_addr, reg_wdata[7:0], reg_wdata[15:8]));

  assign reg_re = (state_q == S_RD_STB);
  assign reg_we = (state_q == S_WR_STB);
  assign busy   = (state_q != S_IDLE);

  always_ff @(posedge clk_48) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Reply states load the holding register once, then hold until the byte is taken.
  always_comb begin
    state_d       = state_q;
    rx_data_ready = 1'b0;
    tx_load       = 1'b0;
    tx_byte       = 8'h00;
    case (state_q)
      S_IDLE: begin
        rx_data_ready = 1'b1;
        if (rx_fire) begin
          if (rx_data[7:6] == OP_READ)       state_d = S_RD_STB;
          else if (rx_data[7:6] == OP_WRITE) state_d = S_WR_LO;
          else                               state_d = S_RESP_1;
        end
      end
      S_RD_STB: state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_RESP_LO;
      S_RESP_LO: begin
        tx_load = !tx_data_valid;
        tx_byte = rdata_q[7:0];
        if (tx_fire) state_d = S_RESP_HI;
      end
      S_RESP_HI: begin
        tx_load = !tx_data_valid;
        tx_byte = rdata_q[15:8];
        if (tx_fire) state_d = S_IDLE;
      end
      S_WR_LO: begin
        rx_data_ready = 1'b1;
        if (tmo_hit)      state_d = S_IDLE;
        else if (rx_fire) state_d = S_WR_HI;
      end
      S_WR_HI: begin
        rx_data_ready = 1'b1;
        if (tmo_hit) state_d = S_IDLE;
        else if (rx_fire) begin
`ifdef UART_CMD_CHECKSUM_EN
          state_d = S_WR_CHK;
`else
          state_d = S_WR_STB;
`endif
        end
      end
      S_WR_CHK: begin
`ifdef UART_CMD_CHECKSUM_EN
        rx_data_ready = 1'b1;
        if (tmo_hit)      state_d = S_IDLE;
        else if (rx_fire) state_d = chk_ok ? S_WR_STB : S_RESP_1;
`else
        state_d = S_IDLE;
`endif
      end
      S_WR_STB: state_d = S_RESP_ACK;
      S_RESP_ACK: begin
        tx_load = !tx_data_valid;
        tx_byte = ACK_REPLY;
        if (tx_fire) state_d = S_IDLE;
      end
      S_RESP_1: begin
        tx_load = !tx_data_valid;
        tx_byte = reply_q;
        if (tx_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_48) begin
    if (rst) begin
      tmo_cnt       <= '0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      rdata_q       <= '0;
      reply_q       <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
    end else begin
      // Inter-byte idle timer: only meaningful while a write packet is open.
      if (rx_fire || !in_wr) tmo_cnt <= '0;
      else                   tmo_cnt <= tmo_cnt + CNT_W'(1);

      if (rx_fire) begin
        case (state_q)
          S_IDLE: begin
            reg_addr <= rx_data[5:0];
            reply_q  <= (rx_data == PING_OP) ? PING_REPLY : ERR_REPLY;
          end
          S_WR_LO:  reg_wdata[7:0]  <= rx_data;
          S_WR_HI:  reg_wdata[15:8] <= rx_data;
          S_WR_CHK: reply_q         <= ERR_REPLY;
          default: ;
        endcase
      end

      if (state_q == S_RD_CAP) rdata_q <= reg_rdata;

      if (tx_fire) begin
        tx_data_valid <= 1'b0;
      end else if (tx_load) begin
        tx_data       <= tx_byte;
        tx_data_valid <= 1'b1;
      end
    end
  end

endmodule
